// File: rtl/game_flow_ctrl.sv
// HEROE console game-flow controller: power, welcome, character select, play,
// pause, win/lose display and play-again prompt, driven by keypad and game result.
module game_flow_ctrl #(
    parameter int          TICK_DIV   = 27000000,
    parameter int          GAME_DELAY = 3,
    parameter int          WL_TICKS   = 15,
    parameter int          PA_TIMEOUT = 30,
    parameter int          TW         = 8,
    parameter logic [4:0]  KEY_PWR    = 5'd10,
    parameter logic [4:0]  KEY_STB    = 5'd13,
    parameter logic [4:0]  KEY_NO     = 5'd14,
    parameter logic [4:0]  KEY_YES    = 5'd15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          keypad_pressed,
    input  logic [4:0]    key,
    input  logic [1:0]    W_or_L,
    output logic [2:0]    presente,
    output logic [1:0]    result,
    output logic [TW-1:0] state_timer,
    output logic          state_changed
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_WLCM  = 3'd1,
        S_CH    = 3'd2,
        S_GAME  = 3'd3,
        S_WL    = 3'd4,
        S_PA    = 3'd5,
        S_PAUSE = 3'd6
    } state_t;

    localparam int            CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [TW-1:0] GD_T      = TW'(GAME_DELAY);
    localparam logic [TW-1:0] WL_T      = TW'(WL_TICKS);
    localparam logic [TW-1:0] PA_T      = TW'(PA_TIMEOUT);

    state_t        r_state;
    logic [CW-1:0] r_tick_cnt;
    logic          r_pressed_q;
    logic          r_armed;
    logic [1:0]    r_result;
    logic [TW-1:0] r_timer;
    logic          r_state_changed;

    logic          w_tick;
    logic          w_press;
    logic          w_pwr;
    logic          w_stb;
    logic          w_yes;
    logic          w_no;
    logic          w_result_valid;
    logic [TW-1:0] w_timer_inc;

    assign w_tick  = (r_tick_cnt == TICK_LAST);
    // r_armed blocks a key that was already held when reset released.
    assign w_press = keypad_pressed & ~r_pressed_q & r_armed;
    assign w_pwr   = w_press && (key == KEY_PWR);
    assign w_stb   = w_press && (key == KEY_STB);
    assign w_yes   = w_press && (key == KEY_YES);
    assign w_no    = w_press && (key == KEY_NO);

    assign w_result_valid = (W_or_L == 2'b01) || (W_or_L == 2'b10);
    assign w_timer_inc    = (r_timer == {TW{1'b1}}) ? r_timer : r_timer + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_OFF;
            r_tick_cnt      <= '0;
            r_pressed_q     <= 1'b0;
            r_armed         <= 1'b0;
            r_result        <= 2'b00;
            r_timer         <= '0;
            r_state_changed <= 1'b0;
        end else begin
            r_pressed_q     <= keypad_pressed;
            r_tick_cnt      <= w_tick ? '0 : r_tick_cnt + CW'(1);
            r_state_changed <= 1'b0;
            if (!keypad_pressed) begin
                r_armed <= 1'b1;
            end

            // Key commands take precedence over any timer transition.
            if (w_pwr) begin
                r_state         <= (r_state == S_OFF) ? S_WLCM : S_OFF;
                r_timer         <= '0;
                r_result        <= 2'b00;
                r_state_changed <= 1'b1;
            end else if (w_stb && (r_state == S_WLCM || r_state == S_CH)) begin
                r_state         <= (r_state == S_WLCM) ? S_CH : S_GAME;
                r_timer         <= '0;
                r_result        <= 2'b00;
                r_state_changed <= 1'b1;
            end else if (w_stb && (r_state == S_GAME || r_state == S_PAUSE)) begin
                // The timer is carried across GAME<->PAUSE untouched.
                r_state         <= (r_state == S_GAME) ? S_PAUSE : S_GAME;
                r_result        <= 2'b00;
                r_state_changed <= 1'b1;
            end else if ((w_yes || w_no) && r_state == S_PA) begin
                r_state         <= w_yes ? S_GAME : S_WLCM;
                r_timer         <= '0;
                r_result        <= 2'b00;
                r_state_changed <= 1'b1;
            end else begin
                case (r_state)
                    S_GAME: begin
                        if (!w_result_valid) begin
                            r_timer <= '0;
                        end else if (w_tick) begin
                            if (w_timer_inc >= GD_T) begin
                                r_state         <= S_WL;
                                r_result        <= W_or_L;
                                r_timer         <= '0;
                                r_state_changed <= 1'b1;
                            end else begin
                                r_timer <= w_timer_inc;
                            end
                        end
                    end
                    S_WL: begin
                        if (w_tick) begin
                            if (w_timer_inc >= WL_T) begin
                                r_state         <= S_PA;
                                r_timer         <= '0;
                                r_state_changed <= 1'b1;
                            end else begin
                                r_timer <= w_timer_inc;
                            end
                        end
                    end
                    S_PA: begin
                        if (w_tick) begin
                            // A zero timeout leaves PA waiting for an answer forever.
                            if (PA_TIMEOUT != 0 && w_timer_inc >= PA_T) begin
                                r_state         <= S_WLCM;
                                r_timer         <= '0;
                                r_result        <= 2'b00;
                                r_state_changed <= 1'b1;
                            end else begin
                                r_timer <= w_timer_inc;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign presente      = r_state;
    assign result        = r_result;
    assign state_timer   = r_timer;
    assign state_changed = r_state_changed;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: two instances sharing stimulus, one with
// the play-again timeout enabled (6 ticks) and one with it disabled.
module tb_game_flow_ctrl;

    localparam logic [4:0] K_PWR = 5'd10;
    localparam logic [4:0] K_STB = 5'd13;
    localparam logic [4:0] K_NO  = 5'd14;
    localparam logic [4:0] K_YES = 5'd15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       keypad_pressed = 1'b0;
    logic [4:0] key = 5'd0;
    logic [1:0] W_or_L = 2'b00;

    logic [2:0] presente,  presente0;
    logic [1:0] result,    result0;
    logic [7:0] state_timer, state_timer0;
    logic       state_changed, state_changed0;

    int n_cmp = 0;
    int n_err = 0;
    int tb_cnt;

    game_flow_ctrl #(.TICK_DIV(4), .GAME_DELAY(3), .WL_TICKS(5), .PA_TIMEOUT(6), .TW(8)) u_dut (
        .clk(clk), .rst(rst), .keypad_pressed(keypad_pressed), .key(key), .W_or_L(W_or_L),
        .presente(presente), .result(result), .state_timer(state_timer), .state_changed(state_changed)
    );

    game_flow_ctrl #(.TICK_DIV(4), .GAME_DELAY(3), .WL_TICKS(5), .PA_TIMEOUT(0), .TW(8)) u_dut0 (
        .clk(clk), .rst(rst), .keypad_pressed(keypad_pressed), .key(key), .W_or_L(W_or_L),
        .presente(presente0), .result(result0), .state_timer(state_timer0), .state_changed(state_changed0)
    );

    always #5 clk = ~clk;

    // Reference tick phase: the edge sampled while tb_cnt==3 carries a tick.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        bit was;
        for (int i = 0; i < n; i++) begin
            do begin
                was = (tb_cnt == 3);
                @(negedge clk);
            end while (!was);
        end
    endtask

    task automatic press_key(input logic [4:0] k);
        keypad_pressed = 1'b1;
        key = k;
        @(negedge clk);
        keypad_pressed = 1'b0;
        @(negedge clk);
    endtask

    // From GAME, win/lose held 3 ticks then 5 ticks of WL lands in PA.
    task automatic reach_pa(input logic [1:0] w);
        wait_ticks(1);
        W_or_L = w;
        wait_ticks(3);
        W_or_L = 2'b00;
        wait_ticks(5);
        n_cmp++; if (presente !== 3'd5) begin n_err++; $display("FAIL reach_pa: got %0d want 5", presente); end
        n_cmp++; if (result !== w) begin n_err++; $display("FAIL reach_pa_result: got %b want %b", result, w); end
    endtask

    task automatic restart_to_game();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        keypad_pressed = 1'b0;
        W_or_L = 2'b00;
        @(negedge clk);
        press_key(K_PWR);
        press_key(K_STB);
        press_key(K_STB);
        n_cmp++; if (presente !== 3'd3 || presente0 !== 3'd3) begin n_err++; $display("FAIL restart: got %0d/%0d want 3/3", presente, presente0); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        keypad_pressed = 1'b1;
        key = K_PWR;
        repeat (3) @(negedge clk);
        n_cmp++; if ({presente, result, state_timer, state_changed} !== 14'd0) begin n_err++; $display("FAIL reset_vals: got %0d/%b/%0d/%b want 0/00/0/0", presente, result, state_timer, state_changed); end
        n_cmp++; if ({presente0, result0, state_timer0, state_changed0} !== 14'd0) begin n_err++; $display("FAIL reset_vals0: got %0d/%b/%0d/%b want 0/00/0/0", presente0, result0, state_timer0, state_changed0); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (presente !== 3'd0) begin n_err++; $display("FAIL held_over_reset: got %0d want 0", presente); end
        keypad_pressed = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_power_up();
        logic [4:0] keys [3];
        logic [2:0] exp_s [3];
        keys = '{K_PWR, K_STB, K_STB};
        exp_s = '{3'd1, 3'd2, 3'd3};
        for (int i = 0; i < 3; i++) begin
            keypad_pressed = 1'b1;
            key = keys[i];
            @(negedge clk);
            n_cmp++; if (presente !== exp_s[i]) begin n_err++; $display("FAIL power_up_state%0d: got %0d want %0d", i, presente, exp_s[i]); end
            n_cmp++; if (state_changed !== 1'b1) begin n_err++; $display("FAIL power_up_pulse%0d: got %b want 1", i, state_changed); end
            keypad_pressed = 1'b0;
            @(negedge clk);
            n_cmp++; if (state_changed !== 1'b0) begin n_err++; $display("FAIL power_up_pulse_end%0d: got %b want 0", i, state_changed); end
        end
    endtask

    task automatic test_win_path();
        wait_ticks(1);
        W_or_L = 2'b10;
        wait_ticks(2);
        n_cmp++; if (presente !== 3'd3 || state_timer !== 8'd2) begin n_err++; $display("FAIL game_count: got %0d/%0d want 3/2", presente, state_timer); end
        wait_ticks(1);
        n_cmp++; if (presente !== 3'd4 || result !== 2'b10 || state_timer !== 8'd0) begin n_err++; $display("FAIL enter_wl: got %0d/%b/%0d want 4/10/0", presente, result, state_timer); end
        W_or_L = 2'b00;
        wait_ticks(4);
        n_cmp++; if (presente !== 3'd4 || result !== 2'b10 || state_timer !== 8'd4) begin n_err++; $display("FAIL wl_hold: got %0d/%b/%0d want 4/10/4", presente, result, state_timer); end
        wait_ticks(1);
        n_cmp++; if (presente !== 3'd5 || result !== 2'b10 || state_timer !== 8'd0) begin n_err++; $display("FAIL enter_pa: got %0d/%b/%0d want 5/10/0", presente, result, state_timer); end
    endtask

    task automatic test_pa_answers();
        press_key(K_YES);
        n_cmp++; if (presente !== 3'd3 || result !== 2'b00 || state_timer !== 8'd0) begin n_err++; $display("FAIL pa_yes: got %0d/%b/%0d want 3/00/0", presente, result, state_timer); end
        reach_pa(2'b10);
        press_key(K_NO);
        n_cmp++; if (presente !== 3'd1 || result !== 2'b00) begin n_err++; $display("FAIL pa_no: got %0d/%b want 1/00", presente, result); end
    endtask

    task automatic test_pa_timeout();
        press_key(K_STB);
        press_key(K_STB);
        reach_pa(2'b01);
        wait_ticks(5);
        n_cmp++; if (presente !== 3'd5 || state_timer !== 8'd5) begin n_err++; $display("FAIL pa_wait: got %0d/%0d want 5/5", presente, state_timer); end
        wait_ticks(1);
        n_cmp++; if (presente !== 3'd1 || result !== 2'b00) begin n_err++; $display("FAIL pa_timeout: got %0d/%b want 1/00", presente, result); end
        n_cmp++; if (presente0 !== 3'd5 || state_timer0 !== 8'd6) begin n_err++; $display("FAIL pa_no_timeout: got %0d/%0d want 5/6", presente0, state_timer0); end
        wait_ticks(50);
        n_cmp++; if (presente0 !== 3'd5 || result0 !== 2'b01 || state_timer0 !== 8'd56) begin n_err++; $display("FAIL pa_hold_long: got %0d/%b/%0d want 5/01/56", presente0, result0, state_timer0); end
    endtask

    task automatic test_pause();
        wait_ticks(1);
        W_or_L = 2'b01;
        wait_ticks(2);
        n_cmp++; if (state_timer !== 8'd2) begin n_err++; $display("FAIL pre_pause: got %0d want 2", state_timer); end
        press_key(K_STB);
        n_cmp++; if (presente !== 3'd6 || state_timer !== 8'd2) begin n_err++; $display("FAIL enter_pause: got %0d/%0d want 6/2", presente, state_timer); end
        W_or_L = 2'b00;
        wait_ticks(10);
        n_cmp++; if (presente !== 3'd6 || state_timer !== 8'd2) begin n_err++; $display("FAIL pause_frozen: got %0d/%0d want 6/2", presente, state_timer); end
        W_or_L = 2'b01;
        press_key(K_STB);
        n_cmp++; if (presente !== 3'd3 || state_timer !== 8'd2) begin n_err++; $display("FAIL resume: got %0d/%0d want 3/2", presente, state_timer); end
        wait_ticks(1);
        n_cmp++; if (presente !== 3'd4 || result !== 2'b01) begin n_err++; $display("FAIL resume_wl: got %0d/%b want 4/01", presente, result); end
        W_or_L = 2'b00;
        wait_ticks(5);
        press_key(K_YES);
        n_cmp++; if (presente !== 3'd3) begin n_err++; $display("FAIL back_to_game: got %0d want 3", presente); end
    endtask

    task automatic test_drop_and_hold();
        int pulses;
        wait_ticks(1);
        W_or_L = 2'b01;
        wait_ticks(1);
        n_cmp++; if (state_timer !== 8'd1) begin n_err++; $display("FAIL drop_pre: got %0d want 1", state_timer); end
        W_or_L = 2'b00;
        @(negedge clk);
        n_cmp++; if (state_timer !== 8'd0) begin n_err++; $display("FAIL drop_clear: got %0d want 0", state_timer); end
        wait_ticks(4);
        n_cmp++; if (presente !== 3'd3 || state_timer !== 8'd0) begin n_err++; $display("FAIL drop_no_wl: got %0d/%0d want 3/0", presente, state_timer); end
        pulses = 0;
        keypad_pressed = 1'b1;
        key = K_STB;
        repeat (20) begin
            @(negedge clk);
            if (state_changed) pulses++;
        end
        keypad_pressed = 1'b0;
        @(negedge clk);
        n_cmp++; if (pulses !== 1 || presente !== 3'd6) begin n_err++; $display("FAIL hold_stb: got %0d pulses/state %0d want 1/6", pulses, presente); end
        press_key(K_STB);
    endtask

    task automatic test_pwr_collisions();
        wait_ticks(1);
        W_or_L = 2'b10;
        wait_ticks(3);
        W_or_L = 2'b00;
        wait_ticks(4);
        repeat (3) @(negedge clk);
        n_cmp++; if (presente !== 3'd4 || state_timer !== 8'd4) begin n_err++; $display("FAIL pre_expiry: got %0d/%0d want 4/4", presente, state_timer); end
        press_key(K_PWR);
        n_cmp++; if (presente !== 3'd0 || state_timer !== 8'd0 || result !== 2'b00) begin n_err++; $display("FAIL pwr_beats_tick: got %0d/%0d/%b want 0/0/00", presente, state_timer, result); end
        wait_ticks(1);
        repeat (3) @(negedge clk);
        press_key(K_PWR);
        n_cmp++; if (presente !== 3'd1 || state_timer !== 8'd0) begin n_err++; $display("FAIL pwr_off_tick: got %0d/%0d want 1/0", presente, state_timer); end
    endtask

    task automatic test_reset_mid_wl();
        press_key(K_STB);
        press_key(K_STB);
        wait_ticks(1);
        W_or_L = 2'b01;
        wait_ticks(3);
        wait_ticks(2);
        n_cmp++; if (presente !== 3'd4 || state_timer !== 8'd2) begin n_err++; $display("FAIL mid_wl: got %0d/%0d want 4/2", presente, state_timer); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({presente, result, state_timer, state_changed} !== 14'd0) begin n_err++; $display("FAIL async_reset: got %0d/%b/%0d/%b want 0/00/0/0", presente, result, state_timer, state_changed); end
        @(negedge clk);
        rst = 1'b0;
        W_or_L = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_power_up();
        test_win_path();
        test_pa_answers();
        test_pa_timeout();
        restart_to_game();
        test_pause();
        test_drop_and_hold();
        test_pwr_collisions();
        test_reset_mid_wl();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
